// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS register file slice.
package mips_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_ADDR_WIDTH = 5;
   localparam int REG_ZERO           = 0;

   typedef enum logic {
      CLEAR,
      READY
   } regfile_state_t;

endpackage

// File: rtl/mips_regfile_clear_ctrl.sv
// Sweep controller: walks every register address once after reset or a clear
// request, then raises ready.
module mips_regfile_clear_ctrl
   import mips_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signal_clear,
   output logic                  ready,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

   regfile_state_t        state_q;
   logic [ADDR_WIDTH-1:0] clr_idx_q;
   logic                  ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_idx_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               clr_idx_q <= clr_idx_q + 1'b1;
               if (clr_idx_q == LAST_IDX) begin
                  state_q <= READY;
                  ready_q <= 1'b1;
               end
            end
            READY: begin
               if (signal_clear) begin
                  state_q   <= CLEAR;
                  clr_idx_q <= '0;
                  ready_q   <= 1'b0;
               end
            end
            default: begin
               state_q   <= CLEAR;
               clr_idx_q <= '0;
               ready_q   <= 1'b0;
            end
         endcase
      end
   end

   assign ready    = ready_q;
   assign clr_we   = (state_q == CLEAR) && !rst;
   assign clr_addr = clr_idx_q;

endmodule

// File: rtl/mips_register_file.sv
// Two-read/one-write register file with hardwired r0 and a self-clearing sweep.
// Define MIPS_REGFILE_BYPASS_EN for write-first forwarding on same-address access.
module mips_register_file
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signal_clear,
   input  logic                  signal_reg_write,
   input  logic [ADDR_WIDTH-1:0] write_reg,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] read_reg_1,
   input  logic [ADDR_WIDTH-1:0] read_reg_2,
   output logic [DATA_WIDTH-1:0] read_data_1,
   output logic [DATA_WIDTH-1:0] read_data_2,
   output logic                  ready
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  user_we;

   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [DATA_WIDTH-1:0] regs_d [DEPTH];
   logic [DATA_WIDTH-1:0] read_data_1_q, read_data_1_d;
   logic [DATA_WIDTH-1:0] read_data_2_q, read_data_2_d;

   mips_regfile_clear_ctrl #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_clear_ctrl (
      .clk         (clk),
      .rst         (rst),
      .signal_clear(signal_clear),
      .ready       (ready),
      .clr_we      (clr_we),
      .clr_addr    (clr_addr)
   );

   // A clear request in READY takes priority over a write in the same cycle.
   assign user_we = ready && !rst && !signal_clear && signal_reg_write &&
                    (write_reg != ZERO_ADDR);

   always_comb begin
      regs_d = regs_q;
      if (clr_we) begin
         regs_d[clr_addr] = '0;
      end else if (user_we) begin
         regs_d[write_reg] = write_data;
      end
   end

   always_comb begin
      read_data_1_d = '0;
      read_data_2_d = '0;
      if (ready) begin
         if (read_reg_1 != ZERO_ADDR) begin
            read_data_1_d = regs_q[read_reg_1];
         end
         if (read_reg_2 != ZERO_ADDR) begin
            read_data_2_d = regs_q[read_reg_2];
         end
`ifdef MIPS_REGFILE_BYPASS_EN
         if (user_we && (read_reg_1 == write_reg)) begin
            read_data_1_d = write_data;
         end
         if (user_we && (read_reg_2 == write_reg)) begin
            read_data_2_d = write_data;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      regs_q <= regs_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         read_data_1_q <= '0;
         read_data_2_q <= '0;
      end else begin
         read_data_1_q <= read_data_1_d;
         read_data_2_q <= read_data_2_d;
      end
   end

   assign read_data_1 = read_data_1_q;
   assign read_data_2 = read_data_2_q;

endmodule

// File: tb/tb_mips_register_file.sv
// Directed self-checking bench for mips_register_file (default 32x32 geometry).
module tb_mips_register_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        signal_clear;
   logic        signal_reg_write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [4:0]  read_reg_1;
   logic [4:0]  read_reg_2;
   logic [31:0] read_data_1;
   logic [31:0] read_data_2;
   logic        ready;

   int tests_run    = 0;
   int tests_failed = 0;

   mips_register_file dut (
      .clk             (clk),
      .rst             (rst),
      .signal_clear    (signal_clear),
      .signal_reg_write(signal_reg_write),
      .write_reg       (write_reg),
      .write_data      (write_data),
      .read_reg_1      (read_reg_1),
      .read_reg_2      (read_reg_2),
      .read_data_1     (read_data_1),
      .read_data_2     (read_data_2),
      .ready           (ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      signal_clear     = 1'b0;
      signal_reg_write = 1'b0;
      write_reg        = 5'd0;
      write_data       = 32'd0;
   endtask

   task automatic write_one(input logic [4:0] addr, input logic [31:0] data);
      signal_reg_write = 1'b1;
      write_reg        = addr;
      write_data       = data;
      tick();
      signal_reg_write = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      read_reg_1 = 5'd0;
      read_reg_2 = 5'd0;
      rst = 1'b1;
      tick();
      tick();
      tests_run++;
      if (ready !== 1'b0 || read_data_1 !== 32'd0 || read_data_2 !== 32'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_values got ready=%0b rd1=%h rd2=%h exp 0/0/0",
                  ready, read_data_1, read_data_2);
      end
      rst = 1'b0;
      for (int i = 1; i <= 31; i++) begin
         tick();
         tests_run++;
         if (ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL sweep_not_ready edge=%0d got=%0b exp=0", i, ready);
         end
      end
      tick();
      tests_run++;
      if (ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL sweep_ready edge=32 got=%0b exp=1", ready);
      end
      for (int i = 0; i < 32; i++) begin
         read_reg_1 = 5'(i);
         read_reg_2 = 5'(31 - i);
         tick();
         tests_run++;
         if (read_data_1 !== 32'd0 || read_data_2 !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL cleared_read idx=%0d got=%h/%h exp=0/0",
                     i, read_data_1, read_data_2);
         end
      end
   endtask

   task automatic test_write_read();
      write_one(5'd5, 32'hDEADBEEF);
      read_reg_1 = 5'd5;
      read_reg_2 = 5'd5;
      tick();
      tests_run++;
      if (read_data_1 !== 32'hDEADBEEF || read_data_2 !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("[TB] FAIL write_read_r5 got=%h/%h exp=deadbeef/deadbeef",
                  read_data_1, read_data_2);
      end
   endtask

   task automatic test_reg_zero();
      write_one(5'd0, 32'hFFFFFFFF);
      read_reg_1 = 5'd0;
      read_reg_2 = 5'd0;
      tick();
      tests_run++;
      if (read_data_1 !== 32'd0 || read_data_2 !== 32'd0) begin
         tests_failed++;
         $display("[TB] FAIL reg_zero got=%h/%h exp=0/0", read_data_1, read_data_2);
      end
      // same-cycle write/read of r0 must never forward
      signal_reg_write = 1'b1;
      write_reg        = 5'd0;
      write_data       = 32'h0000ABCD;
      tick();
      signal_reg_write = 1'b0;
      tests_run++;
      if (read_data_1 !== 32'd0) begin
         tests_failed++;
         $display("[TB] FAIL reg_zero_same_cycle got=%h exp=0", read_data_1);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] exp_same;
`ifdef MIPS_REGFILE_BYPASS_EN
      exp_same = 32'h00001234;
`else
      exp_same = 32'h00000055;
`endif
      write_one(5'd7, 32'h00000055);
      read_reg_1       = 5'd7;
      read_reg_2       = 5'd5;
      signal_reg_write = 1'b1;
      write_reg        = 5'd7;
      write_data       = 32'h00001234;
      tick();
      signal_reg_write = 1'b0;
      tests_run++;
      if (read_data_1 !== exp_same || read_data_2 !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("[TB] FAIL same_addr_rw got=%h/%h exp=%h/deadbeef",
                  read_data_1, read_data_2, exp_same);
      end
      tick();
      tests_run++;
      if (read_data_1 !== 32'h00001234) begin
         tests_failed++;
         $display("[TB] FAIL after_same_addr_rw got=%h exp=00001234", read_data_1);
      end
   endtask

   task automatic test_back_to_back();
      write_one(5'd10, 32'hA0A0A0A0);
      read_reg_1 = 5'd10;
      read_reg_2 = 5'd11;
      write_one(5'd11, 32'hB1B1B1B1);
      tests_run++;
      if (read_data_1 !== 32'hA0A0A0A0) begin
         tests_failed++;
         $display("[TB] FAIL b2b_first got=%h exp=a0a0a0a0", read_data_1);
      end
      tick();
      tests_run++;
      if (read_data_1 !== 32'hA0A0A0A0 || read_data_2 !== 32'hB1B1B1B1) begin
         tests_failed++;
         $display("[TB] FAIL b2b_both got=%h/%h exp=a0a0a0a0/b1b1b1b1",
                  read_data_1, read_data_2);
      end
   endtask

   task automatic test_clear();
      write_one(5'd1, 32'h11111111);
      write_one(5'd2, 32'h22222222);
      write_one(5'd3, 32'h33333333);
      read_reg_1       = 5'd1;
      read_reg_2       = 5'd2;
      signal_clear     = 1'b1;
      signal_reg_write = 1'b1;
      write_reg        = 5'd4;
      write_data       = 32'h44444444;
      tick();
      idle_inputs();
      tests_run++;
      if (ready !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL clear_ready_drop got=%0b exp=0", ready);
      end
      for (int i = 1; i <= 31; i++) begin
         // a late write during the sweep lands behind the index and must be ignored
         if (i == 20) begin
            signal_reg_write = 1'b1;
            write_reg        = 5'd9;
            write_data       = 32'h00000099;
         end else begin
            signal_reg_write = 1'b0;
         end
         tick();
         tests_run++;
         if (ready !== 1'b0 || read_data_1 !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL clear_busy edge=%0d got ready=%0b rd1=%h exp 0/0",
                     i, ready, read_data_1);
         end
      end
      signal_reg_write = 1'b0;
      tick();
      tests_run++;
      if (ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL clear_ready_back got=%0b exp=1", ready);
      end
      for (int i = 1; i <= 11; i++) begin
         read_reg_1 = 5'(i);
         read_reg_2 = 5'(i);
         tick();
         tests_run++;
         if (read_data_1 !== 32'd0 || read_data_2 !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL after_clear idx=%0d got=%h/%h exp=0/0",
                     i, read_data_1, read_data_2);
         end
      end
   endtask

   task automatic test_reset_mid_sweep();
      write_one(5'd6, 32'h66666666);
      read_reg_1 = 5'd6;
      read_reg_2 = 5'd6;
      rst = 1'b1;
      tick();
      tests_run++;
      if (ready !== 1'b0 || read_data_1 !== 32'd0 || read_data_2 !== 32'd0) begin
         tests_failed++;
         $display("[TB] FAIL rst_from_ready got ready=%0b rd=%h/%h exp 0/0/0",
                  ready, read_data_1, read_data_2);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      // clear requests inside the sweep must not restart it
      signal_clear = 1'b1;
      for (int i = 1; i <= 31; i++) begin
         tick();
         tests_run++;
         if (ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL restart_not_ready edge=%0d got=%0b exp=0", i, ready);
         end
      end
      signal_clear = 1'b0;
      tick();
      tests_run++;
      if (ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL restart_ready edge=32 got=%0b exp=1", ready);
      end
      tick();
      tests_run++;
      if (read_data_1 !== 32'd0) begin
         tests_failed++;
         $display("[TB] FAIL restart_cleared_r6 got=%h exp=0", read_data_1);
      end
   endtask

   initial begin
      rst        = 1'b1;
      read_reg_1 = 5'd0;
      read_reg_2 = 5'd0;
      idle_inputs();
      test_reset();
      test_write_read();
      test_reg_zero();
      test_bypass();
      test_back_to_back();
      test_clear();
      test_reset_mid_sweep();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
